// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single unified instruction/data RAM port between
// instruction fetch (IF) and the load/store unit (LS). Each granted request is
// latched, drives the RAM for one ACCESS cycle, then returns data with a
// one-cycle rvalid pulse.
// Optional macro RAM_ARB_RR_EN: round-robin on contention. When it is undefined,
// LS has fixed priority and IF is forced to win after STARVE_LIMIT losses.
module ram_arbiter #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] MEM_BASE     = '0,
  parameter logic [XLEN-1:0] MEM_DEPTH    = XLEN'(16'hffff),
  parameter int unsigned     STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [2:0]      ls_size,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            ls_err,
  output logic            ram_en,
  output logic            ram_read_flag,
  output logic            ram_write_flag,
  output logic [XLEN-1:0] ram_read_addr,
  output logic [XLEN-1:0] ram_write_addr,
  output logic [XLEN-1:0] ram_write_data,
  output logic [2:0]      ram_write_size,
  input  logic [XLEN-1:0] ram_read_data
);

  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
  // Largest legal offset from MEM_BASE (last full word inside the window).
  localparam logic [XLEN:0]   SPAN = {1'b0, MEM_DEPTH} - (XLEN+1)'(4);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic            cur_ls;
  logic            cur_we;
  logic            cur_ok;
  logic            arb_c;
  logic            pick_ls_c;
  logic            sel_we_c;
  logic            sel_ok_c;
  logic [XLEN-1:0] sel_addr_c;

  // An address below MEM_BASE wraps to a huge offset, so one compare suffices.
  function automatic logic legal_addr(input logic [XLEN-1:0] a);
    logic [XLEN:0] off;
    off = {1'b0, a} - {1'b0, MEM_BASE};
    return off <= SPAN;
  endfunction

`ifdef RAM_ARB_RR_EN
  logic last_win_if;

  // Remember the last winner so contention alternates between requesters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win_if <= 1'b1;
    end else if (if_gnt) begin
      last_win_if <= 1'b1;
    end else if (ls_gnt) begin
      last_win_if <= 1'b0;
    end
  end
`else
  localparam int unsigned CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Count consecutive IF losses; an IF win clears the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (ls_gnt && if_req) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  // Arbitration and selection of the winning payload (grants are combinational).
  always_comb begin
    arb_c     = rst && (state != ACCESS);
    pick_ls_c = ls_req;
    if (ls_req && if_req) begin
`ifdef RAM_ARB_RR_EN
      pick_ls_c = last_win_if;
`else
      pick_ls_c = (starve_cnt != CNT_W'(STARVE_LIMIT));
`endif
    end
    ls_gnt     = arb_c && ls_req && pick_ls_c;
    if_gnt     = arb_c && if_req && !pick_ls_c;
    sel_addr_c = ls_gnt ? ls_addr : if_addr;
    sel_we_c   = ls_gnt && ls_we;
    sel_ok_c   = legal_addr(sel_addr_c);
  end

  // Main FSM: latch the grant, drive the RAM for one cycle, return the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cur_ls         <= 1'b0;
      cur_we         <= 1'b0;
      cur_ok         <= 1'b0;
      if_rvalid      <= 1'b0;
      if_rdata       <= '0;
      ls_rvalid      <= 1'b0;
      ls_rdata       <= '0;
      ls_err         <= 1'b0;
      ram_en         <= 1'b0;
      ram_read_flag  <= 1'b0;
      ram_write_flag <= 1'b0;
      ram_read_addr  <= '0;
      ram_write_addr <= '0;
      ram_write_data <= '0;
      ram_write_size <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (if_gnt || ls_gnt) begin
            state          <= ACCESS;
            cur_ls         <= ls_gnt;
            cur_we         <= sel_we_c;
            cur_ok         <= sel_ok_c;
            ram_en         <= sel_ok_c;
            ram_read_flag  <= sel_ok_c && !sel_we_c;
            ram_write_flag <= sel_ok_c && sel_we_c;
            ram_read_addr  <= (sel_ok_c && !sel_we_c) ? sel_addr_c : '0;
            ram_write_addr <= (sel_ok_c && sel_we_c) ? sel_addr_c : '0;
            ram_write_data <= (sel_ok_c && sel_we_c) ? ls_wdata : '0;
            ram_write_size <= (sel_ok_c && sel_we_c) ? ls_size : 3'd0;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state          <= RESP;
          ram_en         <= 1'b0;
          ram_read_flag  <= 1'b0;
          ram_write_flag <= 1'b0;
          ram_read_addr  <= '0;
          ram_write_addr <= '0;
          ram_write_data <= '0;
          ram_write_size <= 3'd0;
          if (cur_ls) begin
            ls_rvalid <= 1'b1;
            ls_err    <= !cur_ok;
            ls_rdata  <= (cur_ok && !cur_we) ? ram_read_data : '0;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= cur_ok ? ram_read_data : NOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// serial transactions checked against a byte-level golden memory.
module tb_ram_arbiter;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] MEM_BASE     = 32'h0;
  localparam logic [31:0] MEM_DEPTH    = 32'h0000_ffff;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam logic [2:0]  SZ_B         = 3'd0;
  localparam logic [2:0]  SZ_H         = 3'd1;
  localparam logic [2:0]  SZ_W         = 3'd2;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_size;
  logic        ram_en, ram_read_flag, ram_write_flag;
  logic [31:0] ram_read_addr, ram_write_addr, ram_write_data, ram_read_data;
  logic [2:0]  ram_write_size;
  logic        ram_init;

  logic [7:0]  mem  [0:65535];
  logic [7:0]  gold [0:65535];
  logic [15:0] ra;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_if_rd, exp_ls_rd;

  ram_arbiter #(
    .XLEN(XLEN), .MEM_BASE(MEM_BASE), .MEM_DEPTH(MEM_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_size(ls_size),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_en(ram_en), .ram_read_flag(ram_read_flag), .ram_write_flag(ram_write_flag),
    .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data), .ram_write_size(ram_write_size),
    .ram_read_data(ram_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic int size_bytes(input logic [2:0] s);
    return (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(MEM_BASE);
    return (off >= 0) && (off <= longint'(MEM_DEPTH) - 4);
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [15:0] b;
    b = a[15:0];
    return {gold[b + 16'd3], gold[b + 16'd2], gold[b + 16'd1], gold[b]};
  endfunction

  // Byte-addressed little-endian RAM with combinational read.
  always_comb begin
    ra            = ram_read_addr[15:0];
    ram_read_data = {mem[ra + 16'd3], mem[ra + 16'd2], mem[ra + 16'd1], mem[ra]};
  end

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
    end else if (ram_en && ram_write_flag) begin
      for (int k = 0; k < 4; k++)
        if (k < size_bytes(ram_write_size))
          mem[ram_write_addr[15:0] + 16'(k)] <= ram_write_data[8*k +: 8];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_if_rd = '0;
    exp_ls_rd = '0;
  endtask

  // One serial transaction from an idle arbiter, checked cycle by cycle.
  task automatic txn(input string tag, input bit is_ls, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] size);
    bit          ok;
    int          got_at;
    logic [31:0] word;
    ok     = legal(addr);
    word   = gold_word(addr);
    got_at = 8;
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_size = size;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (is_ls ? ls_gnt : if_gnt) begin
        got_at = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "/gnt_wait"}, 32'(got_at), 32'd0);
    chk({tag, "/other_gnt"}, 32'(is_ls ? if_gnt : ls_gnt), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk({tag, "/ram_en"}, 32'(ram_en), 32'(ok));
    if (ok) begin
      if (is_ls && we) begin
        chk({tag, "/wflag"}, 32'(ram_write_flag), 32'd1);
        chk({tag, "/rflag"}, 32'(ram_read_flag), 32'd0);
        chk({tag, "/waddr"}, ram_write_addr, addr);
        chk({tag, "/wdata"}, ram_write_data, wdata);
        chk({tag, "/wsize"}, 32'(ram_write_size), 32'(size));
      end else begin
        chk({tag, "/rflag"}, 32'(ram_read_flag), 32'd1);
        chk({tag, "/wflag"}, 32'(ram_write_flag), 32'd0);
        chk({tag, "/raddr"}, ram_read_addr, addr);
      end
    end
    @(negedge clk);
    if (is_ls) begin
      if (!ok) exp_ls_rd = '0;
      else if (we) begin
        exp_ls_rd = '0;
        for (int k = 0; k < size_bytes(size); k++) gold[addr[15:0] + 16'(k)] = wdata[8*k +: 8];
      end else exp_ls_rd = word;
    end else begin
      exp_if_rd = ok ? word : NOP;
    end
    chk({tag, "/if_rvalid"}, 32'(if_rvalid), 32'(!is_ls));
    chk({tag, "/ls_rvalid"}, 32'(ls_rvalid), 32'(is_ls));
    chk({tag, "/ls_err"}, 32'(ls_err), 32'(is_ls && !ok));
    chk({tag, "/if_rdata"}, if_rdata, exp_if_rd);
    chk({tag, "/ls_rdata"}, ls_rdata, exp_ls_rd);
    chk({tag, "/ram_idle"}, 32'({ram_en, ram_write_flag}), 32'd0);
  endtask

  bit          r_ls, r_we, e_ls, lw_if;
  logic [31:0] r_addr, r_data;
  logic [2:0]  r_sz;
  int          g, lastc, scnt;

  initial begin
    rst = 1'b0; ram_init = 1'b1;
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_size = SZ_W;
    exp_if_rd = '0; exp_ls_rd = '0;
    for (int i = 0; i < 65536; i++) gold[i] = pat(16'(i));

    // Reset with a pending fetch: everything quiet, then grant on release.
    @(posedge clk); #1; ram_init = 1'b0;
    @(negedge clk);
    chk("rst/if_gnt", 32'(if_gnt), 32'd0);
    chk("rst/ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst/ctrl", 32'({ram_en, ram_read_flag, ram_write_flag, if_rvalid, ls_rvalid, ls_err}), 32'd0);
    chk("rst/if_rdata", if_rdata, 32'd0);
    chk("rst/ram_raddr", ram_read_addr, 32'd0);
    rst = 1'b1; #1;
    chk("rst/release_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    chk("rst/raddr", ram_read_addr, 32'h20);
    @(negedge clk);
    chk("rst/if_rvalid", 32'(if_rvalid), 32'd1);
    exp_if_rd = gold_word(32'h20);
    chk("rst/if_rdata_word", if_rdata, exp_if_rd);

    // Single fetch, store/load round trip, range boundaries.
    txn("fetch10", 1'b0, 1'b0, 32'h10, '0, SZ_W);
    txn("sw100", 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, SZ_W);
    txn("lw100", 1'b1, 1'b0, 32'h100, '0, SZ_W);
    chk("lw100/deadbeef", ls_rdata, 32'hDEAD_BEEF);
    txn("sb101", 1'b1, 1'b1, 32'h101, 32'h0000_0077, SZ_B);
    txn("sh102", 1'b1, 1'b1, 32'h102, 32'h0000_1234, SZ_H);
    txn("lw100b", 1'b1, 1'b0, 32'h100, '0, SZ_W);
    txn("ld_top", 1'b1, 1'b0, MEM_BASE + MEM_DEPTH - 32'd4, '0, SZ_W);
    txn("ld_oob", 1'b1, 1'b0, MEM_BASE + MEM_DEPTH, '0, SZ_W);
    txn("st_oob", 1'b1, 1'b1, 32'h0001_0000, 32'h1111_2222, SZ_W);
    txn("if_oob", 1'b0, 1'b0, MEM_BASE + MEM_DEPTH, '0, SZ_W);

    // Randomized serial traffic against the golden memory.
    for (int t = 0; t < 40; t++) begin
      r_ls   = 1'($urandom_range(0, 1));
      r_we   = r_ls && ($urandom_range(0, 1) == 1);
      r_addr = ($urandom_range(0, 7) == 0) ? 32'h0000_fffc + 32'($urandom_range(0, 256))
                                           : 32'($urandom_range(0, 32'h3ff));
      r_data = $urandom;
      r_sz   = 3'($urandom_range(0, 2));
      txn("rand", r_ls, r_we, r_addr, r_data, r_sz);
    end

    // Both requesters held: grant order and 2-cycle spacing.
    do_reset();
    g = 0; lastc = 0; scnt = 0; lw_if = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
    for (int c = 0; c < 40; c++) begin
      if (g < 10) begin
        @(negedge clk);
        if (if_gnt || ls_gnt) begin
          chk("cont/both", 32'(if_gnt && ls_gnt), 32'd0);
`ifdef RAM_ARB_RR_EN
          e_ls  = lw_if;
          lw_if = !e_ls;
`else
          e_ls = (scnt != STARVE_LIMIT);
          scnt = e_ls ? scnt + 1 : 0;
`endif
          chk("cont/winner_ls", 32'(ls_gnt), 32'(e_ls));
          if (g > 0) chk("cont/spacing", 32'(c - lastc), 32'd2);
          lastc = c;
          g++;
        end
        @(posedge clk); #1;
      end
    end
    chk("cont/grants", 32'(g), 32'd10);
    if_req = 1'b0; ls_req = 1'b0;

    // Reset during a store's ACCESS cycle: no write, arbiter idle afterwards.
    do_reset();
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hCAFE_F00D; ls_size = SZ_W;
    @(negedge clk);
    chk("abort/gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1; ls_req = 1'b0;
    chk("abort/access_en", 32'(ram_en), 32'd1);
    #2; rst = 1'b0; #1;
    chk("abort/en_drop", 32'({ram_en, ram_write_flag}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort/no_rvalid", 32'(ls_rvalid), 32'd0);
    rst = 1'b1;
    exp_if_rd = '0; exp_ls_rd = '0;
    txn("abort/readback", 1'b1, 1'b0, 32'h200, '0, SZ_W);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
